// File: rtl/fuzzy_t2_defuzz_seq.sv
// Sequential interval Type-2 defuzzifier using the Nie-Tan centroid.
// Each accepted rule beat adds (up+low)*cent to a numerator and (up+low)
// to a denominator. At frame end a restoring divider produces the crisp
// output one quotient bit per cycle, MSB first. The result is held until
// the consumer accepts it.
module fuzzy_t2_defuzz_seq #(
  parameter int unsigned   W       = 8,
  parameter int unsigned   N_RULES = 9,
  parameter bit            ROUND   = 1'b0,
  parameter logic [W-1:0]  DEF_OUT = W'(128)
) (
  input  logic         clk_0,
  input  logic         Srst_n,
  input  logic         rule_valid,
  output logic         rule_ready,
  input  logic [W-1:0] rule_up,
  input  logic [W-1:0] rule_low,
  input  logic [W-1:0] rule_cent,
  input  logic         rule_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] saida_defuzzy,
  output logic         fou_zero,
  output logic         cnt_err
);

  localparam int unsigned CLG    = $clog2(N_RULES);
  localparam int unsigned S_W    = W + 1;
  localparam int unsigned PROD_W = 2 * W + 1;
  localparam int unsigned NUM_W  = PROD_W + CLG;
  localparam int unsigned DEN_W  = S_W + CLG;
  // One spare bit so the rounding offset can never wrap the numerator.
  localparam int unsigned REM_W  = NUM_W + 1;
  localparam int unsigned CNT_W  = $clog2(N_RULES + 1);
  localparam int unsigned DC_W   = $clog2(W + 1);

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    DIVIDE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  // Numerator offset for round-half-up; zero when truncating.
  function automatic logic [REM_W-1:0] round_adj(input logic [NUM_W-1:0] n,
                                                 input logic [DEN_W-1:0] d);
    logic [REM_W-1:0] off;
    off = ROUND ? REM_W'(d >> 1) : '0;
    return REM_W'(n) + off;
  endfunction

  // Clamp the quotient to full scale when the rounded mean overflows W bits.
  function automatic logic [W-1:0] sat_quot(input logic [W-1:0] q,
                                            input logic         ovf);
    return ovf ? '1 : q;
  endfunction

  state_t            state_q, state_d;
  logic [NUM_W-1:0]  num_q, num_d;
  logic [DEN_W-1:0]  den_q, den_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [REM_W-1:0]  rem_q, rem_d;
  logic [REM_W-1:0]  dsh_q, dsh_d;
  logic [W-1:0]      quo_q, quo_d;
  logic              ovf_q, ovf_d;
  logic [DC_W-1:0]   div_cnt_q, div_cnt_d;
  logic              rule_ready_q, rule_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [W-1:0]      saida_q, saida_d;
  logic              fou_zero_q, fou_zero_d;
  logic              cnt_err_q, cnt_err_d;

  logic [S_W-1:0]    s;
  logic [PROD_W-1:0] prod;
  logic              beat;
  logic              frame_end;
  logic              qbit;

  assign rule_ready    = rule_ready_q;
  assign out_valid     = out_valid_q;
  assign saida_defuzzy = saida_q;
  assign fou_zero      = fou_zero_q;
  assign cnt_err       = cnt_err_q;

  // Next-state logic: accumulate beats, run the divider, hold the result.
  always_comb begin
    state_d      = state_q;
    num_d        = num_q;
    den_d        = den_q;
    cnt_d        = cnt_q;
    rem_d        = rem_q;
    dsh_d        = dsh_q;
    quo_d        = quo_q;
    ovf_d        = ovf_q;
    div_cnt_d    = div_cnt_q;
    out_valid_d  = out_valid_q;
    saida_d      = saida_q;
    fou_zero_d   = fou_zero_q;
    cnt_err_d    = cnt_err_q;
    qbit         = 1'b0;

    s         = S_W'(rule_up) + S_W'(rule_low);
    prod      = PROD_W'(s) * PROD_W'(rule_cent);
    beat      = rule_valid & rule_ready_q;
    frame_end = beat & (rule_last | (cnt_q == CNT_W'(N_RULES - 1)));

    case (state_q)
      ACCUM: begin
        if (beat) begin
          num_d = num_q + NUM_W'(prod);
          den_d = den_q + DEN_W'(s);
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (frame_end) begin
          // Flags both a short frame closed by rule_last and a full frame
          // whose final beat did not carry rule_last.
          cnt_err_d = (cnt_q != CNT_W'(N_RULES - 1)) | ~rule_last;
          cnt_d     = '0;
          div_cnt_d = '0;
          state_d   = DIVIDE;
        end
      end

      DIVIDE: begin
        if (div_cnt_q == '0) begin
          // Setup cycle: zero-weight frames bypass the divider entirely.
          if (den_q == '0) begin
            saida_d     = DEF_OUT;
            fou_zero_d  = 1'b1;
            out_valid_d = 1'b1;
            state_d     = HOLD;
          end else begin
            fou_zero_d = 1'b0;
            rem_d      = round_adj(num_q, den_q);
            dsh_d      = REM_W'(den_q) << (W - 1);
            ovf_d      = rem_d >= (REM_W'(den_q) << W);
            quo_d      = '0;
            div_cnt_d  = DC_W'(1);
          end
        end else begin
          // One restoring step: subtract the aligned divisor when it fits.
          if (rem_q >= dsh_q) begin
            rem_d = rem_q - dsh_q;
            qbit  = 1'b1;
          end
          quo_d = (quo_q << 1) | W'(qbit);
          dsh_d = dsh_q >> 1;
          if (div_cnt_q == DC_W'(W)) begin
            saida_d     = sat_quot(quo_d, ovf_q);
            out_valid_d = 1'b1;
            state_d     = HOLD;
          end else begin
            div_cnt_d = div_cnt_q + DC_W'(1);
          end
        end
      end

      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          num_d       = '0;
          den_d       = '0;
          state_d     = ACCUM;
        end
      end

      default: begin
        state_d = ACCUM;
      end
    endcase

    rule_ready_d = (state_d == ACCUM);
  end

  // State and datapath registers; reset abandons any frame in flight.
  always_ff @(posedge clk_0 or negedge Srst_n) begin
    if (!Srst_n) begin
      state_q      <= ACCUM;
      num_q        <= '0;
      den_q        <= '0;
      cnt_q        <= '0;
      rem_q        <= '0;
      dsh_q        <= '0;
      quo_q        <= '0;
      ovf_q        <= 1'b0;
      div_cnt_q    <= '0;
      rule_ready_q <= 1'b1;
      out_valid_q  <= 1'b0;
      saida_q      <= '0;
      fou_zero_q   <= 1'b0;
      cnt_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      num_q        <= num_d;
      den_q        <= den_d;
      cnt_q        <= cnt_d;
      rem_q        <= rem_d;
      dsh_q        <= dsh_d;
      quo_q        <= quo_d;
      ovf_q        <= ovf_d;
      div_cnt_q    <= div_cnt_d;
      rule_ready_q <= rule_ready_d;
      out_valid_q  <= out_valid_d;
      saida_q      <= saida_d;
      fou_zero_q   <= fou_zero_d;
      cnt_err_q    <= cnt_err_d;
    end
  end

endmodule

// File: tb/tb_fuzzy_t2_defuzz_seq.sv
// Scoreboard bench for fuzzy_t2_defuzz_seq (W=8, N_RULES=3, DEF_OUT=128).
// A truncating and a rounding instance share the same rule stream; each has
// its own expected-result queue drained by a monitor on output handshakes.
module tb_fuzzy_t2_defuzz_seq;

  logic       clk_0;
  logic       Srst_n;
  logic       rule_valid;
  logic [7:0] rule_up, rule_low, rule_cent;
  logic       rule_last;
  logic       out_ready;

  logic       rule_ready, out_valid, fou_zero, cnt_err;
  logic [7:0] saida_defuzzy;
  logic       rule_ready_r, out_valid_r, fou_zero_r, cnt_err_r;
  logic [7:0] saida_defuzzy_r;

  typedef struct {
    int saida;
    int fz;
    int ce;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int errors = 0;
  int checks = 0;

  fuzzy_t2_defuzz_seq #(.W(8), .N_RULES(3), .ROUND(1'b0), .DEF_OUT(8'd128)) dut (
    .clk_0(clk_0), .Srst_n(Srst_n),
    .rule_valid(rule_valid), .rule_ready(rule_ready),
    .rule_up(rule_up), .rule_low(rule_low), .rule_cent(rule_cent),
    .rule_last(rule_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .saida_defuzzy(saida_defuzzy), .fou_zero(fou_zero), .cnt_err(cnt_err)
  );

  fuzzy_t2_defuzz_seq #(.W(8), .N_RULES(3), .ROUND(1'b1), .DEF_OUT(8'd128)) dut_r (
    .clk_0(clk_0), .Srst_n(Srst_n),
    .rule_valid(rule_valid), .rule_ready(rule_ready_r),
    .rule_up(rule_up), .rule_low(rule_low), .rule_cent(rule_cent),
    .rule_last(rule_last),
    .out_valid(out_valid_r), .out_ready(out_ready),
    .saida_defuzzy(saida_defuzzy_r), .fou_zero(fou_zero_r), .cnt_err(cnt_err_r)
  );

  initial clk_0 = 1'b0;
  always #5 clk_0 = ~clk_0;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  task automatic push_exp(input int s0, input int s1, input int fz, input int ce);
    exp_t e;
    e.saida = s0; e.fz = fz; e.ce = ce;
    q0.push_back(e);
    e.saida = s1;
    q1.push_back(e);
  endtask

  // Called at #1 after a rising edge; returns at #1 after the accepting edge.
  task automatic send(input int up, input int low, input int c, input bit last);
    int n;
    n = 0;
    rule_up    = 8'(up);
    rule_low   = 8'(low);
    rule_cent  = 8'(c);
    rule_last  = last;
    rule_valid = 1'b1;
    while (!rule_ready && n < 200) begin
      @(posedge clk_0); #1;
      n++;
    end
    if (n >= 200) fail_now("send_ready");
    @(posedge clk_0); #1;
    rule_valid = 1'b0;
    rule_last  = 1'b0;
  endtask

  // Counts edges from the last beat until out_valid rises.
  task automatic latency(input string name, input int expv);
    int k;
    k = 0;
    while (!out_valid && k < 50) begin
      @(posedge clk_0); #1;
      k++;
    end
    if (!out_valid) fail_now(name);
    else chk(name, k, expv);
  endtask

  task automatic wait_valid(input string name);
    int k;
    k = 0;
    while (!out_valid && k < 50) begin
      @(posedge clk_0); #1;
      k++;
    end
    if (!out_valid) fail_now(name);
  endtask

  // Monitor: compare every accepted result against the scoreboard.
  always @(negedge clk_0) begin
    exp_t e;
    if (Srst_n && out_ready) begin
      if (out_valid) begin
        if (q0.size() == 0) fail_now("unexpected_out_trunc");
        else begin
          e = q0.pop_front();
          chk("saida_trunc", int'(saida_defuzzy), e.saida);
          chk("fou_zero_trunc", int'(fou_zero), e.fz);
          chk("cnt_err_trunc", int'(cnt_err), e.ce);
        end
      end
      if (out_valid_r) begin
        if (q1.size() == 0) fail_now("unexpected_out_round");
        else begin
          e = q1.pop_front();
          chk("saida_round", int'(saida_defuzzy_r), e.saida);
          chk("fou_zero_round", int'(fou_zero_r), e.fz);
          chk("cnt_err_round", int'(cnt_err_r), e.ce);
        end
      end
    end
  end

  initial begin
    int k;
    Srst_n     = 1'b0;
    rule_valid = 1'b0;
    rule_up    = '0;
    rule_low   = '0;
    rule_cent  = '0;
    rule_last  = 1'b0;
    out_ready  = 1'b1;

    repeat (3) @(posedge clk_0);
    #1;
    chk("rst_rule_ready", int'(rule_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_saida", int'(saida_defuzzy), 0);
    chk("rst_fou_zero", int'(fou_zero), 0);
    chk("rst_cnt_err", int'(cnt_err), 0);
    Srst_n = 1'b1;
    @(posedge clk_0); #1;

    // Single active rule: mean equals its centroid.
    send(200, 100, 32, 0);
    send(0, 0, 128, 0);
    send(0, 0, 224, 1);
    push_exp(32, 32, 0, 0);
    latency("latency_div", 9);
    @(posedge clk_0); #1;

    // 38250/300 = 127.5: truncation vs round-half-up.
    send(100, 50, 0, 0);
    send(100, 50, 255, 0);
    send(0, 0, 128, 1);
    push_exp(127, 128, 0, 0);
    wait_valid("wait_t2");
    @(posedge clk_0); #1;

    // Zero total firing strength.
    send(0, 0, 10, 0);
    send(0, 0, 20, 0);
    send(0, 0, 30, 1);
    push_exp(128, 128, 1, 0);
    latency("latency_zero", 1);
    @(posedge clk_0); #1;

    // Full-scale result held under back-pressure with junk beats offered.
    out_ready = 1'b0;
    send(255, 255, 255, 0);
    send(255, 255, 255, 0);
    send(255, 255, 255, 1);
    push_exp(255, 255, 0, 0);
    wait_valid("wait_t4");
    for (int i = 0; i < 5; i++) begin
      rule_valid = 1'b1;
      rule_up    = 8'd7;
      rule_low   = 8'd7;
      rule_cent  = 8'd7;
      rule_last  = 1'b1;
      @(posedge clk_0); #1;
      chk("hold_valid", int'(out_valid), 1);
      chk("hold_saida", int'(saida_defuzzy), 255);
      chk("hold_rule_ready", int'(rule_ready), 0);
      chk("hold_fou_zero", int'(fou_zero), 0);
    end
    rule_valid = 1'b0;
    rule_last  = 1'b0;
    out_ready  = 1'b1;
    @(posedge clk_0); #1;
    @(posedge clk_0); #1;

    // Short frame closed by rule_last on the second beat.
    send(60, 60, 10, 0);
    send(60, 60, 30, 1);
    push_exp(20, 20, 0, 1);
    wait_valid("wait_t5a");
    @(posedge clk_0); #1;

    // Frame without rule_last: third beat forces the end, fourth starts anew.
    send(10, 10, 50, 0);
    send(10, 10, 50, 0);
    send(10, 10, 50, 0);
    push_exp(50, 50, 0, 1);
    send(20, 0, 100, 1);
    push_exp(100, 100, 0, 1);
    wait_valid("wait_t5b");
    @(posedge clk_0); #1;

    // Reset while dividing discards the frame.
    send(200, 100, 32, 0);
    send(0, 0, 128, 0);
    send(0, 0, 224, 1);
    repeat (3) @(posedge clk_0);
    #2;
    Srst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_rule_ready", int'(rule_ready), 1);
    chk("mid_rst_saida", int'(saida_defuzzy), 0);
    chk("mid_rst_saida_round", int'(saida_defuzzy_r), 0);
    chk("mid_rst_cnt_err", int'(cnt_err), 0);
    @(negedge clk_0);
    Srst_n = 1'b1;
    @(posedge clk_0); #1;
    send(200, 100, 32, 0);
    send(0, 0, 128, 0);
    send(0, 0, 224, 1);
    push_exp(32, 32, 0, 0);

    k = 0;
    while ((q0.size() != 0 || q1.size() != 0) && k < 100) begin
      @(posedge clk_0); #1;
      k++;
    end
    chk("drain_trunc", q0.size(), 0);
    chk("drain_round", q1.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
